itch_msg_framer: RTL and testbench
==================================

# itch_msg_framer

Splits the ITCH payload byte stream from `eth_udp_parser` into individual ITCH messages. It sits directly downstream of that parser and consumes `itchDataOut` and `itchDataValidOut`. Each MoldUDP64 message block is a 2-byte big-endian length prefix followed by that many message bytes. The block strips the prefix, marks message start and end, exposes the message type and length, and flags malformed or truncated blocks to the book-building logic.

## Interface
Clock is `clkIn`. Reset is `rstIn`, synchronous and active-high.

Parameters:
- `MAX_MSG_LEN`, default 50: largest legal message length in bytes. Longer blocks are dropped.
- `GAP_TIMEOUT`, default 16: consecutive idle cycles in the middle of a block that declare it truncated.

Ports:
- `clkIn`  in  1  system clock (250 MHz domain)
- `rstIn`  in  1  synchronous active-high reset
- `itchDataIn`  in  8  payload byte from the parser
- `itchDataValidIn`  in  1  `itchDataIn` is valid this cycle; no backpressure
- `msgDataOut`  out  8  message byte, prefix removed
- `msgDataValidOut`  out  1  `msgDataOut` is valid
- `msgStartOut`  out  1  first byte of a message (the type byte)
- `msgEndOut`  out  1  last byte of a message
- `msgTypeOut`  out  8  message type, held until the next `msgStartOut`
- `msgLenOut`  out  16  length of the current message, held until the next message
- `msgErrOut`  out  1  single-cycle error pulse
- `errCodeOut`  out  2  error cause: 1 = zero length, 2 = oversize, 3 = timeout/truncation. Held until the next error.
- `msgCountOut`  out  32  count of completed messages; wraps modulo 2^32

## Operation
- States:
  - LEN_HI: wait for the length MSB.
  - LEN_LO: wait for the length LSB.
  - BODY: emit message bytes.
  - DROP: consume bytes with no output.
- LEN_HI → LEN_LO on a valid byte; latch it as `len[15:8]`.
- LEN_LO, on a valid byte, forms `len = {hi, byte}`:
  - `len == 0`: error code 1, go to LEN_HI.
  - `len > MAX_MSG_LEN`: error code 2, go to DROP with remaining = `len`.
  - Otherwise: `msgLenOut <= len`, remaining = `len`, go to BODY.
- BODY:
  - Each valid byte is emitted and decrements remaining (16-bit).
  - The first byte asserts `msgStartOut` and loads `msgTypeOut` in the same cycle.
  - The byte that takes remaining to 0 asserts `msgEndOut`, increments `msgCountOut`, and the state returns to LEN_HI.
  - `len == 1` gives `msgStartOut` and `msgEndOut` on the same byte.
- DROP: each valid byte decrements remaining. No output. At 0, go to LEN_HI. Stream alignment is preserved.
- Idle counter:
  - Counts consecutive cycles with `itchDataValidIn` low while in LEN_LO, BODY or DROP.
  - Clears on any valid byte and in LEN_HI; saturates at `GAP_TIMEOUT`.
  - Reaching `GAP_TIMEOUT` raises error code 3 and returns the state to LEN_HI.
  - No `msgEndOut` is issued for the truncated message, and `msgCountOut` is unchanged.
- Errors never raise `msgDataValidOut`. An invalid input cycle produces no output.

## Timing
- All outputs are registered. Latency from input byte to output byte is 1 cycle.
- Back-to-back input gives back-to-back output: one byte per cycle, no bubbles except the 2 prefix cycles per message.
- Length errors (codes 1 and 2) pulse `msgErrOut` the cycle after the LSB is accepted.
- Timeout (code 3) pulses the cycle after the `GAP_TIMEOUT`-th idle cycle.
- Reset values:
  - State LEN_HI.
  - All valid, start, end and err outputs 0.
  - `msgDataOut`, `msgTypeOut`, `msgLenOut`, `errCodeOut` and `msgCountOut` all 0.
  - Idle counter and remaining counter 0.
- Reset in the middle of a message aborts it with no end and no error. The next valid byte is treated as a length MSB.
- Reset has priority over a valid input in the same cycle.

## Test plan
- Back-to-back messages: input 00 03 53 11 22 00 01 41 with continuous valid.
  - Required output: 53/11/22 with start on 53 and end on 22, `msgTypeOut`=0x53, `msgLenOut`=3.
  - Then 41 with start and end together; `msgCountOut`=2.
- Stall tolerance: same input as above with 5 idle cycles inserted between bytes. Output bytes are identical, each 1 cycle after its input; `msgErrOut` never asserts.
- Zero length: input 00 00 00 02 45 01.
  - Required: error pulse with code 1, then message 45/01 with `msgLenOut`=2.
- Oversize: input 00 40, then 64 filler bytes, then 00 01 58.
  - Required: error pulse with code 2 and no output during the filler.
  - Then message 58 alone; `msgCountOut` increments by 1.
- Truncation: input 00 05 50 01 followed by 16 idle cycles.
  - Required: 50/01 output with no end, error code 3 pulse on the 17th cycle, count unchanged.
  - Then 00 01 59 frames as a single-byte message.
- Reset mid-BODY: after 00 04 53 11, assert `rstIn` for 1 cycle.
  - Required: all outputs 0 including `msgCountOut`.
  - Then 00 01 41 frames normally with count 1.

Source files
------------

// File: rtl/itch_msg_framer.sv
// Splits a MoldUDP64 ITCH payload stream into length-prefixed messages.
// Strips the 2-byte prefix, marks start/end and flags length/truncation errors.
module itch_msg_framer #(
   parameter int unsigned MAX_MSG_LEN = 50,
   parameter int unsigned GAP_TIMEOUT = 16
) (
   input  logic        clkIn,
   input  logic        rstIn,
   input  logic [7:0]  itchDataIn,
   input  logic        itchDataValidIn,
   output logic [7:0]  msgDataOut,
   output logic        msgDataValidOut,
   output logic        msgStartOut,
   output logic        msgEndOut,
   output logic [7:0]  msgTypeOut,
   output logic [15:0] msgLenOut,
   output logic        msgErrOut,
   output logic [1:0]  errCodeOut,
   output logic [31:0] msgCountOut
);

   localparam int unsigned IdleW = $clog2(GAP_TIMEOUT + 1);
   localparam logic [15:0] MaxLen = 16'(MAX_MSG_LEN);
   localparam logic [IdleW-1:0] GapMax = IdleW'(GAP_TIMEOUT);

   typedef enum logic [1:0] {StLenHi, StLenLo, StBody, StDrop} state_e;

   state_e           state_q, state_d;
   logic [7:0]       len_hi_q, len_hi_d;
   logic [15:0]      rem_q, rem_d;
   logic [IdleW-1:0] idle_q, idle_d;
   logic             first_q, first_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             start_q, start_d;
   logic             end_q, end_d;
   logic [7:0]       type_q, type_d;
   logic [15:0]      len_q, len_d;
   logic             err_q, err_d;
   logic [1:0]       code_q, code_d;
   logic [31:0]      count_q, count_d;
   logic [15:0]      len_w;

   always_comb begin
      state_d  = state_q;
      len_hi_d = len_hi_q;
      rem_d    = rem_q;
      idle_d   = idle_q;
      first_d  = first_q;
      data_d   = data_q;
      valid_d  = 1'b0;
      start_d  = 1'b0;
      end_d    = 1'b0;
      type_d   = type_q;
      len_d    = len_q;
      err_d    = 1'b0;
      code_d   = code_q;
      count_d  = count_q;
      len_w    = {len_hi_q, itchDataIn};

      if (state_q == StLenHi || itchDataValidIn) begin
         idle_d = '0;
      end else if (idle_q != GapMax) begin
         idle_d = idle_q + 1'b1;
      end

      unique case (state_q)
         StLenHi: begin
            if (itchDataValidIn) begin
               len_hi_d = itchDataIn;
               state_d  = StLenLo;
            end
         end
         StLenLo: begin
            if (itchDataValidIn) begin
               if (len_w == 16'd0) begin
                  err_d   = 1'b1;
                  code_d  = 2'd1;
                  state_d = StLenHi;
               end else if (len_w > MaxLen) begin
                  err_d   = 1'b1;
                  code_d  = 2'd2;
                  rem_d   = len_w;
                  state_d = StDrop;
               end else begin
                  len_d   = len_w;
                  rem_d   = len_w;
                  first_d = 1'b1;
                  state_d = StBody;
               end
            end
         end
         StBody: begin
            if (itchDataValidIn) begin
               valid_d = 1'b1;
               data_d  = itchDataIn;
               start_d = first_q;
               first_d = 1'b0;
               if (first_q) begin
                  type_d = itchDataIn;
               end
               rem_d = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  end_d   = 1'b1;
                  count_d = count_q + 32'd1;
                  state_d = StLenHi;
               end
            end
         end
         StDrop: begin
            if (itchDataValidIn) begin
               rem_d = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  state_d = StLenHi;
               end
            end
         end
         default: state_d = StLenHi;
      endcase

      // A stalled block is abandoned silently: no end marker, count untouched.
      if (state_q != StLenHi && idle_d == GapMax) begin
         err_d   = 1'b1;
         code_d  = 2'd3;
         first_d = 1'b0;
         state_d = StLenHi;
      end
   end

   always_ff @(posedge clkIn) begin
      if (rstIn) begin
         state_q  <= StLenHi;
         len_hi_q <= '0;
         rem_q    <= '0;
         idle_q   <= '0;
         first_q  <= 1'b0;
         data_q   <= '0;
         valid_q  <= 1'b0;
         start_q  <= 1'b0;
         end_q    <= 1'b0;
         type_q   <= '0;
         len_q    <= '0;
         err_q    <= 1'b0;
         code_q   <= '0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         len_hi_q <= len_hi_d;
         rem_q    <= rem_d;
         idle_q   <= idle_d;
         first_q  <= first_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
         start_q  <= start_d;
         end_q    <= end_d;
         type_q   <= type_d;
         len_q    <= len_d;
         err_q    <= err_d;
         code_q   <= code_d;
         count_q  <= count_d;
      end
   end

   assign msgDataOut      = data_q;
   assign msgDataValidOut = valid_q;
   assign msgStartOut     = start_q;
   assign msgEndOut       = end_q;
   assign msgTypeOut      = type_q;
   assign msgLenOut       = len_q;
   assign msgErrOut       = err_q;
   assign errCodeOut      = code_q;
   assign msgCountOut     = count_q;

endmodule

// File: tb/tb_itch_msg_framer.sv
// Directed bench for itch_msg_framer: framing, stalls, length errors, truncation, reset.
module tb_itch_msg_framer;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  din;
   logic        dv;
   logic [7:0]  msgDataOut;
   logic        msgDataValidOut;
   logic        msgStartOut;
   logic        msgEndOut;
   logic [7:0]  msgTypeOut;
   logic [15:0] msgLenOut;
   logic        msgErrOut;
   logic [1:0]  errCodeOut;
   logic [31:0] msgCountOut;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_count;

   logic [7:0] bt_in [8] = '{8'h00, 8'h03, 8'h53, 8'h11, 8'h22, 8'h00, 8'h01, 8'h41};
   logic       bt_v  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
   logic       bt_s  [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   logic       bt_e  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

   itch_msg_framer #(
      .MAX_MSG_LEN(50),
      .GAP_TIMEOUT(16)
   ) dut (
      .clkIn          (clk),
      .rstIn          (rst),
      .itchDataIn     (din),
      .itchDataValidIn(dv),
      .msgDataOut     (msgDataOut),
      .msgDataValidOut(msgDataValidOut),
      .msgStartOut    (msgStartOut),
      .msgEndOut      (msgEndOut),
      .msgTypeOut     (msgTypeOut),
      .msgLenOut      (msgLenOut),
      .msgErrOut      (msgErrOut),
      .errCodeOut     (errCodeOut),
      .msgCountOut    (msgCountOut)
   );

   always #5 clk = ~clk;

   // Drive one cycle of input, then settle just after the capturing edge.
   task automatic step(input logic v, input logic [7:0] b);
      dv  = v;
      din = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(1'b1, 8'hAA);
      step(1'b0, 8'h00);
      rst = 1'b0;
      checks++;
      if ({msgDataValidOut, msgStartOut, msgEndOut, msgErrOut} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000",
                  {msgDataValidOut, msgStartOut, msgEndOut, msgErrOut});
      end
      checks++;
      if ({msgDataOut, msgTypeOut, msgLenOut, errCodeOut} !== 34'd0) begin
         errors++;
         $display("FAIL reset_fields: got %h expected 0",
                  {msgDataOut, msgTypeOut, msgLenOut, errCodeOut});
      end
      checks++;
      if (msgCountOut !== 32'd0) begin
         errors++;
         $display("FAIL reset_count: got %0d expected 0", msgCountOut);
      end
      exp_count = 32'd0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, bt_in[i]);
         checks++;
         if ({msgDataValidOut, msgStartOut, msgEndOut} !== {bt_v[i], bt_s[i], bt_e[i]}) begin
            errors++;
            $display("FAIL b2b_flags[%0d]: got %b expected %b", i,
                     {msgDataValidOut, msgStartOut, msgEndOut}, {bt_v[i], bt_s[i], bt_e[i]});
         end
         if (bt_v[i]) begin
            checks++;
            if (msgDataOut !== bt_in[i]) begin
               errors++;
               $display("FAIL b2b_data[%0d]: got %h expected %h", i, msgDataOut, bt_in[i]);
            end
         end
         if (i == 4) begin
            checks++;
            if ({msgTypeOut, msgLenOut, msgCountOut} !== {8'h53, 16'd3, exp_count + 32'd1}) begin
               errors++;
               $display("FAIL b2b_first_msg: got type %h len %0d count %0d expected 53 3 %0d",
                        msgTypeOut, msgLenOut, msgCountOut, exp_count + 32'd1);
            end
         end
      end
      exp_count = exp_count + 32'd2;
      checks++;
      if ({msgTypeOut, msgLenOut, msgCountOut} !== {8'h41, 16'd1, exp_count}) begin
         errors++;
         $display("FAIL b2b_second_msg: got type %h len %0d count %0d expected 41 1 %0d",
                  msgTypeOut, msgLenOut, msgCountOut, exp_count);
      end
   endtask

   task automatic test_stall();
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < 5; k++) begin
            step(1'b0, 8'hEE);
            checks++;
            if ({msgDataValidOut, msgErrOut} !== 2'b00) begin
               errors++;
               $display("FAIL stall_idle[%0d.%0d]: got valid/err %b expected 00", i, k,
                        {msgDataValidOut, msgErrOut});
            end
         end
         step(1'b1, bt_in[i]);
         checks++;
         if ({msgDataValidOut, msgStartOut, msgEndOut, msgErrOut} !==
             {bt_v[i], bt_s[i], bt_e[i], 1'b0}) begin
            errors++;
            $display("FAIL stall_flags[%0d]: got %b expected %b", i,
                     {msgDataValidOut, msgStartOut, msgEndOut, msgErrOut},
                     {bt_v[i], bt_s[i], bt_e[i], 1'b0});
         end
         if (bt_v[i]) begin
            checks++;
            if (msgDataOut !== bt_in[i]) begin
               errors++;
               $display("FAIL stall_data[%0d]: got %h expected %h", i, msgDataOut, bt_in[i]);
            end
         end
      end
      exp_count = exp_count + 32'd2;
      checks++;
      if (msgCountOut !== exp_count) begin
         errors++;
         $display("FAIL stall_count: got %0d expected %0d", msgCountOut, exp_count);
      end
   endtask

   task automatic test_zero_len();
      step(1'b1, 8'h00);
      step(1'b1, 8'h00);
      checks++;
      if ({msgErrOut, errCodeOut, msgDataValidOut} !== 4'b1010) begin
         errors++;
         $display("FAIL zero_err: got err/code/valid %b expected 1010",
                  {msgErrOut, errCodeOut, msgDataValidOut});
      end
      step(1'b1, 8'h00);
      checks++;
      if (msgErrOut !== 1'b0) begin
         errors++;
         $display("FAIL zero_err_pulse: got %b expected 0", msgErrOut);
      end
      step(1'b1, 8'h02);
      step(1'b1, 8'h45);
      checks++;
      if ({msgDataValidOut, msgStartOut, msgEndOut, msgDataOut, msgLenOut} !==
          {3'b110, 8'h45, 16'd2}) begin
         errors++;
         $display("FAIL zero_next_start: got v/s/e %b data %h len %0d expected 110 45 2",
                  {msgDataValidOut, msgStartOut, msgEndOut}, msgDataOut, msgLenOut);
      end
      step(1'b1, 8'h01);
      exp_count = exp_count + 32'd1;
      checks++;
      if ({msgDataValidOut, msgStartOut, msgEndOut, msgDataOut, msgCountOut} !==
          {3'b101, 8'h01, exp_count}) begin
         errors++;
         $display("FAIL zero_next_end: got v/s/e %b data %h count %0d expected 101 01 %0d",
                  {msgDataValidOut, msgStartOut, msgEndOut}, msgDataOut, msgCountOut, exp_count);
      end
   endtask

   task automatic test_oversize();
      step(1'b1, 8'h00);
      step(1'b1, 8'h40);
      checks++;
      if ({msgErrOut, errCodeOut, msgDataValidOut} !== 4'b1100) begin
         errors++;
         $display("FAIL over_err: got err/code/valid %b expected 1100",
                  {msgErrOut, errCodeOut, msgDataValidOut});
      end
      for (int i = 0; i < 64; i++) begin
         step(1'b1, 8'(i + 8'h80));
         checks++;
         if ({msgDataValidOut, msgErrOut} !== 2'b00) begin
            errors++;
            $display("FAIL over_filler[%0d]: got valid/err %b expected 00", i,
                     {msgDataValidOut, msgErrOut});
         end
      end
      step(1'b1, 8'h00);
      step(1'b1, 8'h01);
      step(1'b1, 8'h58);
      exp_count = exp_count + 32'd1;
      checks++;
      if ({msgDataValidOut, msgStartOut, msgEndOut, msgDataOut, msgCountOut} !==
          {3'b111, 8'h58, exp_count}) begin
         errors++;
         $display("FAIL over_next: got v/s/e %b data %h count %0d expected 111 58 %0d",
                  {msgDataValidOut, msgStartOut, msgEndOut}, msgDataOut, msgCountOut, exp_count);
      end
   endtask

   task automatic test_max_len();
      step(1'b1, 8'h00);
      step(1'b1, 8'd50);
      for (int i = 0; i < 50; i++) begin
         step(1'b1, 8'(i + 1));
         checks++;
         if ({msgDataValidOut, msgStartOut, msgEndOut, msgErrOut, msgDataOut} !==
             {1'b1, (i == 0), (i == 49), 1'b0, 8'(i + 1)}) begin
            errors++;
            $display("FAIL max_body[%0d]: got v/s/e/err %b data %h", i,
                     {msgDataValidOut, msgStartOut, msgEndOut, msgErrOut}, msgDataOut);
         end
      end
      exp_count = exp_count + 32'd1;
      checks++;
      if ({msgLenOut, msgTypeOut, msgCountOut} !== {16'd50, 8'h01, exp_count}) begin
         errors++;
         $display("FAIL max_fields: got len %0d type %h count %0d expected 50 01 %0d",
                  msgLenOut, msgTypeOut, msgCountOut, exp_count);
      end
      step(1'b1, 8'h00);
      step(1'b1, 8'd51);
      checks++;
      if ({msgErrOut, errCodeOut} !== 3'b110) begin
         errors++;
         $display("FAIL max_plus_one: got err/code %b expected 110", {msgErrOut, errCodeOut});
      end
      for (int i = 0; i < 51; i++) begin
         step(1'b1, 8'h77);
      end
      step(1'b1, 8'h00);
      step(1'b1, 8'h01);
      step(1'b1, 8'h5A);
      exp_count = exp_count + 32'd1;
      checks++;
      if ({msgDataValidOut, msgStartOut, msgEndOut, msgDataOut, msgCountOut} !==
          {3'b111, 8'h5A, exp_count}) begin
         errors++;
         $display("FAIL max_realign: got v/s/e %b data %h count %0d expected 111 5a %0d",
                  {msgDataValidOut, msgStartOut, msgEndOut}, msgDataOut, msgCountOut, exp_count);
      end
   endtask

   task automatic test_truncation();
      step(1'b1, 8'h00);
      step(1'b1, 8'h05);
      step(1'b1, 8'h50);
      checks++;
      if ({msgDataValidOut, msgStartOut, msgDataOut, msgTypeOut, msgLenOut} !==
          {2'b11, 8'h50, 8'h50, 16'd5}) begin
         errors++;
         $display("FAIL trunc_start: got v/s %b data %h type %h len %0d expected 11 50 50 5",
                  {msgDataValidOut, msgStartOut}, msgDataOut, msgTypeOut, msgLenOut);
      end
      step(1'b1, 8'h01);
      checks++;
      if ({msgDataValidOut, msgEndOut, msgDataOut} !== {2'b10, 8'h01}) begin
         errors++;
         $display("FAIL trunc_second: got v/e %b data %h expected 10 01",
                  {msgDataValidOut, msgEndOut}, msgDataOut);
      end
      for (int k = 1; k <= 17; k++) begin
         step(1'b0, 8'h00);
         checks++;
         if ({msgErrOut, msgDataValidOut, msgEndOut} !== {(k == 16), 2'b00}) begin
            errors++;
            $display("FAIL trunc_idle[%0d]: got err/valid/end %b expected %b", k,
                     {msgErrOut, msgDataValidOut, msgEndOut}, {(k == 16), 2'b00});
         end
         if (k == 16) begin
            checks++;
            if ({errCodeOut, msgCountOut} !== {2'd3, exp_count}) begin
               errors++;
               $display("FAIL trunc_code: got code %0d count %0d expected 3 %0d",
                        errCodeOut, msgCountOut, exp_count);
            end
         end
      end
      step(1'b1, 8'h00);
      step(1'b1, 8'h01);
      step(1'b1, 8'h59);
      exp_count = exp_count + 32'd1;
      checks++;
      if ({msgDataValidOut, msgStartOut, msgEndOut, msgDataOut, msgCountOut} !==
          {3'b111, 8'h59, exp_count}) begin
         errors++;
         $display("FAIL trunc_next: got v/s/e %b data %h count %0d expected 111 59 %0d",
                  {msgDataValidOut, msgStartOut, msgEndOut}, msgDataOut, msgCountOut, exp_count);
      end
   endtask

   task automatic test_reset_mid_body();
      step(1'b1, 8'h00);
      step(1'b1, 8'h04);
      step(1'b1, 8'h53);
      step(1'b1, 8'h11);
      checks++;
      if ({msgDataValidOut, msgDataOut} !== {1'b1, 8'h11}) begin
         errors++;
         $display("FAIL rstmid_pre: got valid %b data %h expected 1 11",
                  msgDataValidOut, msgDataOut);
      end
      rst = 1'b1;
      step(1'b1, 8'h22);
      rst = 1'b0;
      checks++;
      if ({msgDataValidOut, msgStartOut, msgEndOut, msgErrOut, msgDataOut, msgTypeOut,
           msgLenOut, errCodeOut, msgCountOut} !== 70'd0) begin
         errors++;
         $display("FAIL rstmid_zero: got %h expected 0",
                  {msgDataValidOut, msgStartOut, msgEndOut, msgErrOut, msgDataOut, msgTypeOut,
                   msgLenOut, errCodeOut, msgCountOut});
      end
      step(1'b1, 8'h00);
      step(1'b1, 8'h01);
      step(1'b1, 8'h41);
      checks++;
      if ({msgDataValidOut, msgStartOut, msgEndOut, msgErrOut, msgDataOut, msgCountOut} !==
          {4'b1110, 8'h41, 32'd1}) begin
         errors++;
         $display("FAIL rstmid_next: got v/s/e/err %b data %h count %0d expected 1110 41 1",
                  {msgDataValidOut, msgStartOut, msgEndOut, msgErrOut}, msgDataOut, msgCountOut);
      end
   endtask

   initial begin
      rst = 1'b1;
      dv  = 1'b0;
      din = 8'h00;
      exp_count = 32'd0;
      test_reset();
      test_back_to_back();
      test_stall();
      test_zero_len();
      test_oversize();
      test_max_len();
      test_truncation();
      test_reset_mid_body();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
